// File: rtl/mips_exec_ctrl_if.sv
// Instruction-field, operand and registered-result bundle for the MIPS execute/control stage.
interface mips_exec_ctrl_if #(
  parameter int unsigned WIDTH = 32
);
  logic [5:0]       opcode;
  logic [5:0]       function_code;
  logic [WIDTH-1:0] alu_src1;
  logic [WIDTH-1:0] read_data2;
  logic [WIDTH-1:0] sign_ext_imm;

  logic             regDst;
  logic             branch;
  logic             memRead;
  logic             memWrite;
  logic             ALUsrc;
  logic             regWrite;
  logic             jump;
  logic             byteOperations;
  logic             move;
  logic [2:0]       ALUop;
  logic [2:0]       alu_ctr;
  logic [WIDTH-1:0] alu_result;
  logic             zero_bit;

  modport master (
    output opcode, function_code, alu_src1, read_data2, sign_ext_imm,
    input  regDst, branch, memRead, memWrite, ALUsrc, regWrite, jump,
           byteOperations, move, ALUop, alu_ctr, alu_result, zero_bit
  );

  modport slave (
    input  opcode, function_code, alu_src1, read_data2, sign_ext_imm,
    output regDst, branch, memRead, memWrite, ALUsrc, regWrite, jump,
           byteOperations, move, ALUop, alu_ctr, alu_result, zero_bit
  );
endinterface

// File: rtl/mips_exec_ctrl.sv
// Main decode, ALU control and ALU evaluation for a single-issue MIPS core.
// Everything is combinational from the inputs and captured one clock later.
module mips_exec_ctrl #(
  parameter int unsigned WIDTH = 32
) (
  input  logic             clock,
  input  logic             reset,
  mips_exec_ctrl_if.slave  bus
);

  localparam int unsigned OP_W = 3;

  logic            reg_dst_c, branch_c, mem_read_c, mem_write_c, alu_src_c;
  logic            reg_write_c, jump_c, byte_ops_c, move_c;
  logic [OP_W-1:0] alu_op_c;
  logic [OP_W-1:0] alu_ctr_c;
  logic [WIDTH-1:0] alu_b_c;
  logic [WIDTH-1:0] alu_res_c;
  logic            zero_c;

  // Opcode decode; unlisted opcodes fall through to an inert ADD class.
  always_comb begin
    reg_dst_c   = 1'b0;
    branch_c    = 1'b0;
    mem_read_c  = 1'b0;
    mem_write_c = 1'b0;
    alu_src_c   = 1'b0;
    reg_write_c = 1'b0;
    jump_c      = 1'b0;
    byte_ops_c  = 1'b0;
    move_c      = 1'b0;
    alu_op_c    = 3'b001;
    case (bus.opcode)
      6'b000000: begin reg_dst_c = 1'b1; reg_write_c = 1'b1; alu_op_c = 3'b000; end
      6'b001000: begin alu_src_c = 1'b1; reg_write_c = 1'b1; alu_op_c = 3'b001; end
      6'b001100: begin alu_src_c = 1'b1; reg_write_c = 1'b1; alu_op_c = 3'b011; end
      6'b001101: begin alu_src_c = 1'b1; reg_write_c = 1'b1; alu_op_c = 3'b100; end
      6'b001010: begin alu_src_c = 1'b1; reg_write_c = 1'b1; alu_op_c = 3'b101; end
      6'b010000: begin alu_src_c = 1'b1; mem_read_c = 1'b1; reg_write_c = 1'b1; end
      6'b010001: begin alu_src_c = 1'b1; mem_write_c = 1'b1; end
      6'b010010: begin
        alu_src_c = 1'b1; mem_read_c = 1'b1; reg_write_c = 1'b1; byte_ops_c = 1'b1;
      end
      6'b010011: begin alu_src_c = 1'b1; mem_write_c = 1'b1; byte_ops_c = 1'b1; end
      6'b010100: begin move_c = 1'b1; reg_write_c = 1'b1; end
      6'b100011,
      6'b100111: begin branch_c = 1'b1; alu_op_c = 3'b010; end
      6'b000010,
      6'b000011: begin jump_c = 1'b1; end
      default:   ;
    endcase
  end

  // ALU control: R-type looks at the function field, everything else at the op class.
  always_comb begin
    alu_ctr_c = 3'b101;
    case (alu_op_c)
      3'b000: begin
        case (bus.function_code)
          6'b100000: alu_ctr_c = 3'b101;
          6'b100010: alu_ctr_c = 3'b110;
          6'b100100: alu_ctr_c = 3'b000;
          6'b100101: alu_ctr_c = 3'b001;
          6'b100110: alu_ctr_c = 3'b010;
          6'b100111: alu_ctr_c = 3'b011;
          6'b101010: alu_ctr_c = 3'b100;
          6'b101011: alu_ctr_c = 3'b111;
          default:   alu_ctr_c = 3'b101;
        endcase
      end
      3'b010:  alu_ctr_c = 3'b110;
      3'b011:  alu_ctr_c = 3'b000;
      3'b100:  alu_ctr_c = 3'b001;
      3'b101:  alu_ctr_c = 3'b100;
      default: alu_ctr_c = 3'b101;
    endcase
  end

  // ALU; add/sub wrap silently.
  always_comb begin
    alu_b_c   = alu_src_c ? bus.sign_ext_imm : bus.read_data2;
    alu_res_c = '0;
    case (alu_ctr_c)
      3'b000: alu_res_c = bus.alu_src1 & alu_b_c;
      3'b001: alu_res_c = bus.alu_src1 | alu_b_c;
      3'b010: alu_res_c = bus.alu_src1 ^ alu_b_c;
      3'b011: alu_res_c = ~(bus.alu_src1 | alu_b_c);
      3'b100: alu_res_c = ($signed(bus.alu_src1) < $signed(alu_b_c)) ? WIDTH'(1) : '0;
      3'b101: alu_res_c = bus.alu_src1 + alu_b_c;
      3'b110: alu_res_c = bus.alu_src1 - alu_b_c;
      3'b111: alu_res_c = (bus.alu_src1 < alu_b_c) ? WIDTH'(1) : '0;
      default: alu_res_c = '0;
    endcase
    zero_c = (alu_res_c == '0);
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      bus.regDst         <= 1'b0;
      bus.branch         <= 1'b0;
      bus.memRead        <= 1'b0;
      bus.memWrite       <= 1'b0;
      bus.ALUsrc         <= 1'b0;
      bus.regWrite       <= 1'b0;
      bus.jump           <= 1'b0;
      bus.byteOperations <= 1'b0;
      bus.move           <= 1'b0;
      bus.ALUop          <= '0;
      bus.alu_ctr        <= '0;
      bus.alu_result     <= '0;
      bus.zero_bit       <= 1'b0;
    end else begin
      bus.regDst         <= reg_dst_c;
      bus.branch         <= branch_c;
      bus.memRead        <= mem_read_c;
      bus.memWrite       <= mem_write_c;
      bus.ALUsrc         <= alu_src_c;
      bus.regWrite       <= reg_write_c;
      bus.jump           <= jump_c;
      bus.byteOperations <= byte_ops_c;
      bus.move           <= move_c;
      bus.ALUop          <= alu_op_c;
      bus.alu_ctr        <= alu_ctr_c;
      bus.alu_result     <= alu_res_c;
      bus.zero_bit       <= zero_c;
    end
  end

endmodule

// File: tb/tb_mips_exec_ctrl.sv
// Directed bench for mips_exec_ctrl: hand-computed vectors checked one edge after they are applied.
module tb_mips_exec_ctrl;

  logic clock = 1'b0;
  logic reset = 1'b1;
  int   n_cmp = 0;
  int   n_err = 0;

  mips_exec_ctrl_if #(.WIDTH(32)) bus ();

  mips_exec_ctrl #(.WIDTH(32)) dut (
    .clock (clock),
    .reset (reset),
    .bus   (bus.slave)
  );

  always #5 clock = ~clock;

  // Flag order: regDst branch memRead memWrite ALUsrc regWrite jump byteOperations move
  function automatic logic [8:0] flags();
    return {bus.regDst, bus.branch, bus.memRead, bus.memWrite, bus.ALUsrc,
            bus.regWrite, bus.jump, bus.byteOperations, bus.move};
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic check_all(input string tag, input logic [8:0] f, input logic [2:0] op,
                           input logic [2:0] ctr, input logic [31:0] res, input logic z);
    check({tag, ".flags"},  32'(flags()),         32'(f));
    check({tag, ".ALUop"},  32'(bus.ALUop),       32'(op));
    check({tag, ".alu_ctr"}, 32'(bus.alu_ctr),    32'(ctr));
    check({tag, ".result"}, bus.alu_result,       res);
    check({tag, ".zero"},   32'(bus.zero_bit),    32'(z));
  endtask

  task automatic drive(input logic [5:0] op, input logic [5:0] fn, input logic [31:0] a,
                       input logic [31:0] b, input logic [31:0] imm);
    bus.opcode        = op;
    bus.function_code = fn;
    bus.alu_src1      = a;
    bus.read_data2    = b;
    bus.sign_ext_imm  = imm;
  endtask

  task automatic step(input logic [5:0] op, input logic [5:0] fn, input logic [31:0] a,
                      input logic [31:0] b, input logic [31:0] imm);
    @(negedge clock);
    drive(op, fn, a, b, imm);
    @(posedge clock);
    #1;
  endtask

  initial begin
    drive(6'b000000, 6'b100000, 32'd5, 32'd7, 32'd0);
    @(posedge clock);
    #1;
    check_all("reset_hold", 9'b000000000, 3'b000, 3'b000, 32'h0, 1'b0);
    @(negedge clock);
    reset = 1'b0;

    step(6'b000000, 6'b100000, 32'd5, 32'd7, 32'h0);
    check_all("r_add", 9'b100001000, 3'b000, 3'b101, 32'd12, 1'b0);

    step(6'b100011, 6'b000000, 32'h1234, 32'h1234, 32'h0);
    check_all("beq_eq", 9'b010000000, 3'b010, 3'b110, 32'h0, 1'b1);

    step(6'b000000, 6'b101010, 32'hFFFFFFFF, 32'd1, 32'h0);
    check_all("slt_neg", 9'b100001000, 3'b000, 3'b100, 32'd1, 1'b0);

    step(6'b000000, 6'b101011, 32'hFFFFFFFF, 32'd1, 32'h0);
    check_all("sltu", 9'b100001000, 3'b000, 3'b111, 32'd0, 1'b1);

    step(6'b010000, 6'b000000, 32'h100, 32'h55, 32'hFFFFFFFC);
    check_all("lw", 9'b001011000, 3'b001, 3'b101, 32'hFC, 1'b0);

    step(6'b010010, 6'b000000, 32'h100, 32'h55, 32'hFFFFFFFC);
    check_all("lb", 9'b001011010, 3'b001, 3'b101, 32'hFC, 1'b0);

    step(6'b000000, 6'b100000, 32'hFFFFFFFF, 32'd1, 32'h0);
    check_all("add_wrap", 9'b100001000, 3'b000, 3'b101, 32'h0, 1'b1);

    step(6'b000000, 6'b100010, 32'd3, 32'd5, 32'h0);
    check_all("r_sub", 9'b100001000, 3'b000, 3'b110, 32'hFFFFFFFE, 1'b0);

    step(6'b001100, 6'b000000, 32'hF0F0, 32'h1, 32'h0FF0);
    check_all("andi", 9'b000011000, 3'b011, 3'b000, 32'h00F0, 1'b0);

    step(6'b001101, 6'b000000, 32'hF0F0, 32'h1, 32'h0FF0);
    check_all("ori", 9'b000011000, 3'b100, 3'b001, 32'hFFF0, 1'b0);

    step(6'b001010, 6'b000000, 32'hFFFFFFFE, 32'd0, 32'hFFFFFFFF);
    check_all("slti", 9'b000011000, 3'b101, 3'b100, 32'd1, 1'b0);

    step(6'b000000, 6'b100110, 32'hFF00, 32'h0FF0, 32'h0);
    check_all("r_xor", 9'b100001000, 3'b000, 3'b010, 32'hF0F0, 1'b0);

    step(6'b000000, 6'b100111, 32'hF0000000, 32'h0000000F, 32'h0);
    check_all("r_nor", 9'b100001000, 3'b000, 3'b011, 32'h0FFFFFF0, 1'b0);

    step(6'b000000, 6'b100101, 32'hA0, 32'h0A, 32'h0);
    check_all("r_or", 9'b100001000, 3'b000, 3'b001, 32'hAA, 1'b0);

    step(6'b010001, 6'b000000, 32'h200, 32'h77, 32'h10);
    check_all("sw", 9'b000110000, 3'b001, 3'b101, 32'h210, 1'b0);

    step(6'b010011, 6'b000000, 32'h200, 32'h77, 32'h10);
    check_all("sb", 9'b000110010, 3'b001, 3'b101, 32'h210, 1'b0);

    step(6'b010100, 6'b000000, 32'd3, 32'd4, 32'd100);
    check_all("move", 9'b000001001, 3'b001, 3'b101, 32'd7, 1'b0);

    step(6'b000011, 6'b000000, 32'd1, 32'd2, 32'd100);
    check_all("jal", 9'b000000100, 3'b001, 3'b101, 32'd3, 1'b0);

    step(6'b000000, 6'b001000, 32'h40, 32'h0, 32'h0);
    check_all("jr", 9'b100001000, 3'b000, 3'b101, 32'h40, 1'b0);

    step(6'b100111, 6'b000000, 32'd1, 32'd2, 32'h0);
    check_all("bne", 9'b010000000, 3'b010, 3'b110, 32'hFFFFFFFF, 1'b0);

    // Mid-stream reset between edges must clear outputs without a clock.
    step(6'b000000, 6'b100000, 32'd5, 32'd7, 32'h0);
    check_all("pre_reset", 9'b100001000, 3'b000, 3'b101, 32'd12, 1'b0);
    #1;
    reset = 1'b1;
    #1;
    check_all("async_reset", 9'b000000000, 3'b000, 3'b000, 32'h0, 1'b0);
    @(posedge clock);
    #1;
    check_all("reset_edge", 9'b000000000, 3'b000, 3'b000, 32'h0, 1'b0);
    @(negedge clock);
    reset = 1'b0;
    drive(6'b111111, 6'b000000, 32'd2, 32'd3, 32'd9);
    @(posedge clock);
    #1;
    check_all("unknown_op", 9'b000000000, 3'b001, 3'b101, 32'd5, 1'b0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/mips_exec_ctrl.md
MIPS_EXEC_CTRL -- requirements
Module: mips_exec_ctrl

Interface
REQ-001 The block SHALL have parameter WIDTH, default 32, giving the datapath width; all requirements below assume 32.
REQ-002 The block SHALL use one clock and an asynchronous, active-high reset.
REQ-003 clock  input  1  rising-edge clock; all outputs are registered on it.
REQ-004 reset  input  1  asynchronous, active-high; clears every output register.
REQ-005 opcode  input  6  instruction bits [31:26].
REQ-006 function_code  input  6  instruction bits [5:0].
REQ-007 alu_src1  input  32  first ALU operand (register rs data).
REQ-008 read_data2  input  32  register rt data.
REQ-009 sign_ext_imm  input  32  sign-extended immediate.
REQ-010 regDst, branch, memRead, memWrite, ALUsrc, regWrite, jump, byteOperations, move  output  1 each  registered control flags.
REQ-011 ALUop  output  3  registered ALU operation class.
REQ-012 alu_ctr  output  3  registered ALU operation code.
REQ-013 alu_result  output  32  registered ALU result.
REQ-014 zero_bit  output  1  registered; 1 when the ALU result is all zeros.

Function
REQ-015 Decode, ALU-control and ALU evaluation SHALL be combinational from the current inputs; all outputs SHALL update on the next rising clock edge (1-cycle latency).
REQ-016 Opcode decode SHALL be as follows; any flag not listed is 0:
 - 000000 R-type: regDst=1, regWrite=1, ALUop=000.
 - 001000 addi: ALUsrc=1, regWrite=1, ALUop=001.
 - 001100 andi: ALUsrc=1, regWrite=1, ALUop=011.
 - 001101 ori: ALUsrc=1, regWrite=1, ALUop=100.
 - 001010 slti: ALUsrc=1, regWrite=1, ALUop=101.
 - 010000 lw: ALUsrc=1, memRead=1, regWrite=1, ALUop=001.
 - 010001 sw: ALUsrc=1, memWrite=1, ALUop=001.
 - 010010 lb: as lw, plus byteOperations=1.
 - 010011 sb: as sw, plus byteOperations=1.
 - 010100 move: move=1, regWrite=1, ALUop=001.
 - 100011 beq and 100111 bne: branch=1, ALUop=010.
 - 000010 j and 000011 jal: jump=1, ALUop=001.
 - Any other opcode: all flags 0, ALUop=001.
REQ-017 ALU-control mapping from ALUop SHALL be: 001 to 101 (ADD), 010 to 110 (SUB), 011 to 000 (AND), 100 to 001 (OR), 101 to 100 (SLT), 110 and 111 to 101.
REQ-018 When ALUop=000, alu_ctr SHALL be derived from function_code: 100000 to 101, 100010 to 110, 100100 to 000, 100101 to 001, 100110 to 010, 100111 to 011, 101010 to 100, 101011 to 111, 001000 (jr) to 101, any other value to 101.
REQ-019 The ALU second operand SHALL be sign_ext_imm when ALUsrc=1 and read_data2 otherwise.
REQ-020 alu_ctr operations SHALL be: 000 a&b, 001 a|b, 010 a^b, 011 ~(a|b), 100 signed a<b (result 1 or 0), 101 a+b, 110 a-b, 111 unsigned a<b (result 1 or 0).
REQ-021 ADD and SUB SHALL wrap modulo 2^32 with no overflow flag or trap.
REQ-022 zero_bit SHALL be computed from the same-cycle ALU result.

Reset
REQ-023 While reset=1, all outputs SHALL be 0, including ALUop=000 and alu_ctr=000.
REQ-024 Reset SHALL take effect immediately on assertion, without waiting for a clock edge.
REQ-025 The first rising edge with reset=0 SHALL load outputs from the current inputs.
REQ-026 Asserting reset mid-stream SHALL discard the pending result, with no output held after release.

Verification
REQ-027 R-type add: opcode 000000, funct 100000, src1 5, rd2 7 -> next edge: alu_result=12, alu_ctr=101, regDst=1, regWrite=1, zero_bit=0.
REQ-028 beq, equal operands: opcode 100011, src1=rd2=0x1234 -> branch=1, alu_ctr=110, alu_result=0, zero_bit=1.
REQ-029 slt with negative operand: funct 101010, src1 0xFFFFFFFF, rd2 1 -> result 1; same operands with sltu (funct 101011) -> result 0.
REQ-030 lw using immediate: opcode 010000, src1 0x100, imm 0xFFFFFFFC, rd2 0x55 -> result 0xFC, memRead=1, ALUsrc=1; lb gives the same result plus byteOperations=1.
REQ-031 Wrap-around: add of 0xFFFFFFFF and 1 -> result 0, zero_bit=1.
REQ-032 Reset check: assert reset between clock edges -> all outputs 0 immediately; an unknown opcode (e.g. 111111) after release -> all flags 0, alu_ctr=101.
